// File: rtl/banco_reg_pkg.sv
// Shared definitions for the banco_reg_sb register file and its pending-write scoreboard.
// Defaults, the hard-wired zero register index and a packed-port slicing helper.
package banco_reg_pkg;

    localparam int DEF_DATA_W  = 32;
    localparam int DEF_ADDR_W  = 5;
    localparam int DEF_NUM_RD  = 2;
    localparam int ZERO_REG    = 0;
    // Widest packed port vector the slice helper accepts.
    localparam int SLICE_VEC_W = 256;

    function automatic logic [SLICE_VEC_W-1:0] port_slice(
        input logic [SLICE_VEC_W-1:0] vec,
        input int unsigned            k,
        input int unsigned            w
    );
        return vec >> (k * w);
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write tags: issue sets a register's bit, writeback clears it, set wins on a tie.
// pend_cnt tracks the number of set bits and is updated on the same edge as the bits.
module reg_scoreboard
    import banco_reg_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  iss_en,
    input  logic [ADDR_W-1:0]     iss_a,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wa,
    output logic [2**ADDR_W-1:0]  pend,
    output logic [ADDR_W:0]       pend_cnt
);

    localparam int NREGS = 2**ADDR_W;

    logic [NREGS-1:0] pend_q, pend_d;
    logic [ADDR_W:0]  cnt_q, cnt_d;
    logic             inc, dec;

    always_comb begin
        pend_d = pend_q;
        if (wr_en)  pend_d[wa]    = 1'b0;
        if (iss_en) pend_d[iss_a] = 1'b1;

        inc = iss_en && !pend_q[iss_a];
        // A clear that is overridden by a same-address issue is not a removal.
        dec = wr_en && pend_q[wa] && !(iss_en && (iss_a == wa));
        cnt_d = cnt_q + {{ADDR_W{1'b0}}, inc} - {{ADDR_W{1'b0}}, dec};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
            cnt_q  <= '0;
        end else begin
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
        end
    end

    assign pend     = pend_q;
    assign pend_cnt = cnt_q;

endmodule

// File: rtl/banco_reg_sb.sv
// MIPS register file with per-port pending-operand flags; register 0 reads as zero.
// Optional same-cycle write-through forwarding when BANCO_REG_BYPASS_EN is defined.
module banco_reg_sb
    import banco_reg_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NUM_RD = DEF_NUM_RD
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        wa,
    input  logic [DATA_W-1:0]        wd,
    input  logic                     iss_v,
    input  logic [ADDR_W-1:0]        iss_a,
    input  logic [NUM_RD*ADDR_W-1:0] ra,
    output logic [NUM_RD*DATA_W-1:0] rd,
    output logic [NUM_RD-1:0]        rd_busy,
    output logic [ADDR_W:0]          pend_cnt
);

    localparam int NREGS = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_REG);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];
    logic [NREGS-1:0]  pend;
    logic              wr_en, iss_en;
    logic [ADDR_W-1:0] ra_k;

    assign wr_en  = we && (wa != ZERO_A);
    assign iss_en = iss_v && (iss_a != ZERO_A);

    always_comb begin
        regs_d = regs_q;
        if (wr_en) regs_d[wa] = wd;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    reg_scoreboard #(.ADDR_W(ADDR_W)) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .iss_en   (iss_en),
        .iss_a    (iss_a),
        .wr_en    (wr_en),
        .wa       (wa),
        .pend     (pend),
        .pend_cnt (pend_cnt)
    );

    // Reads are gated by rst_n so a forwarded write cannot leak out during reset.
    always_comb begin
        rd      = '0;
        rd_busy = '0;
        ra_k    = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            ra_k = ADDR_W'(port_slice(SLICE_VEC_W'(ra), int'(k), ADDR_W));
            if (rst_n && (ra_k != ZERO_A)) begin
                rd[k*DATA_W +: DATA_W] = regs_q[ra_k];
                rd_busy[k]             = pend[ra_k];
`ifdef BANCO_REG_BYPASS_EN
                if (wr_en && (ra_k == wa)) begin
                    rd[k*DATA_W +: DATA_W] = wd;
                    rd_busy[k]             = iss_en && (iss_a == wa);
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_banco_reg_sb.sv
// Randomized and directed bench for banco_reg_sb with a queue-based scoreboard.
module tb_banco_reg_sb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        we = 1'b0;
    logic [4:0]  wa = '0;
    logic [31:0] wd = '0;
    logic        iss_v = 1'b0;
    logic [4:0]  iss_a = '0;
    logic [9:0]  ra = '0;
    logic [63:0] rd;
    logic [1:0]  rd_busy;
    logic [5:0]  pend_cnt;

    banco_reg_sb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (we),
        .wa       (wa),
        .wd       (wd),
        .iss_v    (iss_v),
        .iss_a    (iss_a),
        .ra       (ra),
        .rd       (rd),
        .rd_busy  (rd_busy),
        .pend_cnt (pend_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d0;
        logic [31:0] d1;
        logic        b0;
        logic        b1;
        logic [5:0]  c;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] m_mem [32];
    bit          m_pend [32];
    int          ntests = 0;
    int          nfail  = 0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] expv);
        ntests++;
        if (act !== expv) begin
            nfail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
        end
    endfunction

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < 32; i++) n += m_pend[i] ? 1 : 0;
        return n;
    endfunction

    function automatic void m_clear();
        for (int i = 0; i < 32; i++) begin
            m_mem[i]  = '0;
            m_pend[i] = 1'b0;
        end
    endfunction

    function automatic void m_read(input logic [4:0] a, output logic [31:0] d, output logic b);
        if (a == 5'd0) begin
            d = '0;
            b = 1'b0;
        end else begin
            d = m_mem[a];
            b = m_pend[a];
`ifdef BANCO_REG_BYPASS_EN
            if (we && wa != 5'd0 && a == wa) begin
                d = wd;
                b = iss_v && (iss_a == wa);
            end
`endif
        end
    endfunction

    // Called at posedge+1; drives one cycle of stimulus and queues the expected view.
    task automatic step(input logic we_i, input logic [4:0] wa_i, input logic [31:0] wd_i,
                        input logic iv_i, input logic [4:0] ia_i,
                        input logic [4:0] r0, input logic [4:0] r1);
        exp_t e;
        we = we_i; wa = wa_i; wd = wd_i; iss_v = iv_i; iss_a = ia_i; ra = {r1, r0};
        m_read(r0, e.d0, e.b0);
        m_read(r1, e.d1, e.b1);
        e.c = 6'(m_count());
        exp_q.push_back(e);
        @(posedge clk);
        if (we_i && wa_i != 5'd0) begin
            m_mem[wa_i]  = wd_i;
            m_pend[wa_i] = 1'b0;
        end
        if (iv_i && ia_i != 5'd0) m_pend[ia_i] = 1'b1;
        #1;
    endtask

    task automatic idle(input logic [4:0] r0, input logic [4:0] r1);
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, r0, r1);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("rd0",      rd[31:0],             e.d0);
                chk("rd1",      rd[63:32],            e.d1);
                chk("busy0",    {31'b0, rd_busy[0]},  {31'b0, e.b0});
                chk("busy1",    {31'b0, rd_busy[1]},  {31'b0, e.b1});
                chk("pend_cnt", {26'b0, pend_cnt},    {26'b0, e.c});
            end
        end
    end

    initial begin : stim
        m_clear();
        ra = {5'd9, 5'd3};
        #2;
        chk("por_rd",   rd[31:0] | rd[63:32], 32'd0);
        chk("por_busy", {30'b0, rd_busy},     32'd0);
        chk("por_cnt",  {26'b0, pend_cnt},    32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // register 0 ignores both write and issue
        step(1'b1, 5'd0, 32'hDEADBEEF, 1'b1, 5'd0, 5'd0, 5'd0);
        idle(5'd0, 5'd0);

        // issue r5, write r5 three cycles later
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 5'd5, 5'd0);
        idle(5'd5, 5'd5);
        idle(5'd5, 5'd5);
        step(1'b1, 5'd5, 32'h12345678, 1'b0, 5'd0, 5'd5, 5'd5);
        idle(5'd5, 5'd5);

        // same-address issue+write keeps the tag; mixed-address pair nets zero
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd9, 5'd7);
        step(1'b1, 5'd7, 32'hA5, 1'b1, 5'd7, 5'd7, 5'd9);
        idle(5'd7, 5'd7);
        step(1'b1, 5'd9, 32'h99, 1'b1, 5'd8, 5'd8, 5'd9);
        idle(5'd8, 5'd9);

        // write-through read of r3
        step(1'b1, 5'd3, 32'h1111, 1'b0, 5'd0, 5'd3, 5'd0);
        step(1'b1, 5'd3, 32'hCAFE, 1'b0, 5'd0, 5'd3, 5'd3);
        idle(5'd3, 5'd3);

        // fill the scoreboard, then re-issue an already pending register
        for (int i = 1; i < 32; i++) step(1'b0, 5'd0, 32'd0, 1'b1, 5'(i), 5'(i), 5'(i - 1));
        chk("fill_cnt", {26'b0, pend_cnt}, 32'd31);
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 5'd4, 5'd0);
        idle(5'd4, 5'd31);
        chk("reissue_cnt", {26'b0, pend_cnt}, 32'd31);

        for (int n = 0; n < 600; n++) begin
            step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom(),
                 1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, 31)),
                 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
        end

        // asynchronous reset in the middle of a cycle with traffic on the ports
        step(1'b1, 5'd12, 32'h0BADF00D, 1'b1, 5'd13, 5'd12, 5'd13);
        we = 1'b1; wa = 5'd7; wd = 32'h5A5A5A5A; iss_v = 1'b1; iss_a = 5'd7;
        ra = {5'd13, 5'd7};
        #2 rst_n = 1'b0;
        #1;
        chk("rst_rd0",   rd[31:0],          32'd0);
        chk("rst_rd1",   rd[63:32],         32'd0);
        chk("rst_busy",  {30'b0, rd_busy},  32'd0);
        chk("rst_cnt",   {26'b0, pend_cnt}, 32'd0);
        m_clear();
        we = 1'b0; iss_v = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 32; i++) idle(5'(i), 5'(31 - i));

        @(negedge clk); #1;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
